// File: rtl/game_pkg.sv
// game_pkg -- shared types and defaults for the collision tracker.
//   state_e      : collision FSM state
//   bcd_digit_t  : one BCD digit of the score
//   LIVES_DEFAULT, INVULN_DEFAULT : default parameter values
package game_pkg;

   typedef enum logic [1:0] {
      StPlaying  = 2'd0,
      StInvuln   = 2'd1,
      StGameOver = 2'd2
   } state_e;

   typedef logic [3:0] bcd_digit_t;

   localparam int unsigned LIVES_DEFAULT  = 3;
   localparam int unsigned INVULN_DEFAULT = 60;

endpackage

// File: rtl/bcd_score_counter.sv
// bcd_score_counter -- four-digit BCD score, saturating at 9999.
//   clk   : system clock
//   rst   : asynchronous active-high reset, clears score to 0
//   inc   : one-cycle strobe, adds 1 to the score
//   score : {thousands, hundreds, tens, units}
module bcd_score_counter
   import game_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [15:0] score
);

   logic [15:0] r_score;
   logic [15:0] w_score_next;
   logic        w_carry;
   bcd_digit_t  w_digit;

   // Ripple the +1 through the digits; a 9 rolls to 0 and carries on.
   always_comb begin
      w_score_next = r_score;
      w_carry      = 1'b1;
      w_digit      = '0;
      if (r_score != 16'h9999) begin
         for (int i = 0; i < 4; i++) begin
            w_digit = r_score[i*4 +: 4];
            if (w_carry) begin
               if (w_digit == 4'd9) begin
                  w_score_next[i*4 +: 4] = 4'd0;
               end else begin
                  w_score_next[i*4 +: 4] = w_digit + 4'd1;
                  w_carry                = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_score <= '0;
      end else if (inc) begin
         r_score <= w_score_next;
      end
   end

   assign score = r_score;

endmodule

// File: rtl/collision_tracker.sv
// collision_tracker -- per-frame collision accounting for a shooter game.
// Overlaps are gathered during a frame and evaluated on startOfFrame; the
// result pulses appear one cycle later.
//   clk, rst        : clock, asynchronous active-high reset
//   startOfFrame    : frame boundary pulse
//   playerDR, missleDR, monsterDR : per-pixel draw requests
//   monster_id      : monster being drawn (valid with monsterDR)
//   monster_hit     : pulse, missile hit a monster last frame
//   hit_monster_id  : first monster hit in that frame
//   player_hit      : pulse, counted player hit last frame
//   score           : BCD score
//   lives           : remaining lives
//   invulnerable    : in the post-hit grace period
//   game_over       : game finished, frozen until reset
module collision_tracker
   import game_pkg::*;
#(
   parameter int unsigned LIVES_INIT       = LIVES_DEFAULT,
   parameter int unsigned INVULN_FRAMES    = INVULN_DEFAULT,
   parameter int unsigned MONSTER_ID_WIDTH = 5
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        startOfFrame,
   input  logic                        playerDR,
   input  logic                        missleDR,
   input  logic                        monsterDR,
   input  logic [MONSTER_ID_WIDTH-1:0] monster_id,
   output logic                        monster_hit,
   output logic [MONSTER_ID_WIDTH-1:0] hit_monster_id,
   output logic                        player_hit,
   output logic [15:0]                 score,
   output logic [2:0]                  lives,
   output logic                        invulnerable,
   output logic                        game_over
);

   state_e                      r_state;
   state_e                      w_state_next;
   logic                        r_mm_seen;
   logic                        r_pm_seen;
   logic [MONSTER_ID_WIDTH-1:0] r_mm_id;
   logic [7:0]                  r_frame_cnt;
   logic [2:0]                  r_lives;
   logic                        r_monster_hit;
   logic                        r_player_hit;
   logic [MONSTER_ID_WIDTH-1:0] r_hit_id;

   logic                        w_mm;
   logic                        w_pm;
   logic                        w_mm_eval;
   logic                        w_pm_eval;
   logic [MONSTER_ID_WIDTH-1:0] w_mm_id_eval;
   logic                        w_do_monster_hit;
   logic                        w_do_player_hit;

   assign w_mm = missleDR & monsterDR;
   assign w_pm = playerDR & monsterDR;

   // Evaluation includes overlaps on the startOfFrame cycle itself.
   assign w_mm_eval    = r_mm_seen | w_mm;
   assign w_pm_eval    = r_pm_seen | w_pm;
   assign w_mm_id_eval = r_mm_seen ? r_mm_id : monster_id;

   // Sticky overlap flags, cleared at each frame boundary.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mm_seen <= 1'b0;
         r_pm_seen <= 1'b0;
         r_mm_id   <= '0;
      end else if (startOfFrame) begin
         r_mm_seen <= 1'b0;
         r_pm_seen <= 1'b0;
      end else begin
         if (w_mm && !r_mm_seen) begin
            r_mm_id <= monster_id;
         end
         r_mm_seen <= r_mm_seen | w_mm;
         r_pm_seen <= r_pm_seen | w_pm;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StPlaying;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_next = r_state;
      if (startOfFrame) begin
         unique case (r_state)
            StPlaying: begin
               if (w_pm_eval) begin
                  w_state_next = (r_lives == 3'd1) ? StGameOver : StInvuln;
               end
            end
            StInvuln: begin
               if (r_frame_cnt == 8'd1) begin
                  w_state_next = StPlaying;
               end
            end
            StGameOver: w_state_next = StGameOver;
            default:    w_state_next = StPlaying;
         endcase
      end
   end

   // FSM: outputs and evaluation strobes
   always_comb begin
      invulnerable     = (r_state == StInvuln);
      game_over        = (r_state == StGameOver);
      w_do_monster_hit = startOfFrame && w_mm_eval && (r_state != StGameOver);
      w_do_player_hit  = startOfFrame && w_pm_eval && (r_state == StPlaying);
   end

   // Lives, invulnerability counter and result pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lives       <= LIVES_INIT[2:0];
         r_frame_cnt   <= '0;
         r_monster_hit <= 1'b0;
         r_player_hit  <= 1'b0;
         r_hit_id      <= '0;
      end else begin
         r_monster_hit <= w_do_monster_hit;
         r_player_hit  <= w_do_player_hit;
         if (w_do_monster_hit) begin
            r_hit_id <= w_mm_id_eval;
         end
         if (w_do_player_hit) begin
            r_lives     <= r_lives - 3'd1;
            r_frame_cnt <= INVULN_FRAMES[7:0];
         end else if (startOfFrame && r_state == StInvuln) begin
            r_frame_cnt <= r_frame_cnt - 8'd1;
         end
      end
   end

   bcd_score_counter u_score (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_do_monster_hit),
      .score (score)
   );

   assign monster_hit    = r_monster_hit;
   assign player_hit     = r_player_hit;
   assign hit_monster_id = r_hit_id;
   assign lives          = r_lives;

endmodule
